// File: rtl/video_timing_gen.sv
// Raster timing generator for the pixel-clock domain.
// Emits signed beam position (blanking first, active area at x>=0, y>=0), line/frame strobes,
// sync and data enable, all registered and aligned to the same pixel.
// Optional feature: define VIDEO_TIMING_FRAME_CNT_EN to add a 16-bit wrapping frame counter
// output (o_frame_cnt) that steps together with o_frame.
module video_timing_gen #(
   parameter int P_H_RES       = 640,
   parameter int P_H_FP        = 16,
   parameter int P_H_SYNC      = 96,
   parameter int P_H_BP        = 48,
   parameter int P_V_RES       = 480,
   parameter int P_V_FP        = 10,
   parameter int P_V_SYNC      = 2,
   parameter int P_V_BP        = 33,
   parameter bit P_H_POL       = 1'b0,
   parameter bit P_V_POL       = 1'b0,
   parameter int P_COUNT_WIDTH = 16
) (
   input  logic                            i_clk_pixel,
   input  logic                            i_rst_n,
   input  logic                            i_en,
   output logic signed [P_COUNT_WIDTH-1:0] o_x_pos,
   output logic signed [P_COUNT_WIDTH-1:0] o_y_pos,
   output logic                            o_line,
   output logic                            o_frame,
   output logic                            o_hsync,
   output logic                            o_vsync,
   output logic                            o_de
`ifdef VIDEO_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]                     o_frame_cnt
`endif
);

   // Raster extents in plain integers; blanking sits at negative coordinates.
   localparam int H_START    = -(P_H_FP + P_H_SYNC + P_H_BP);
   localparam int H_END      = P_H_RES - 1;
   localparam int H_SYNC_BEG = H_START + P_H_FP;
   localparam int H_SYNC_END = H_SYNC_BEG + P_H_SYNC;
   localparam int V_START    = -(P_V_FP + P_V_SYNC + P_V_BP);
   localparam int V_END      = P_V_RES - 1;
   localparam int V_SYNC_BEG = V_START + P_V_FP;
   localparam int V_SYNC_END = V_SYNC_BEG + P_V_SYNC;

   // Representable signed range of the position registers.
   localparam longint CNT_MIN = -(64'sd1 <<< (P_COUNT_WIDTH - 1));
   localparam longint CNT_MAX = (64'sd1 <<< (P_COUNT_WIDTH - 1)) - 64'sd1;

   if (longint'(H_START) < CNT_MIN || longint'(H_END) > CNT_MAX ||
       longint'(V_START) < CNT_MIN || longint'(V_END) > CNT_MAX) begin : g_width_err
      $error("video_timing_gen: P_COUNT_WIDTH=%0d too narrow for raster extents",
             P_COUNT_WIDTH);
   end

   typedef logic signed [P_COUNT_WIDTH-1:0] pos_t;

   localparam pos_t H_START_C    = pos_t'(H_START);
   localparam pos_t H_END_C      = pos_t'(H_END);
   localparam pos_t H_SYNC_BEG_C = pos_t'(H_SYNC_BEG);
   localparam pos_t H_SYNC_END_C = pos_t'(H_SYNC_END);
   localparam pos_t V_START_C    = pos_t'(V_START);
   localparam pos_t V_END_C      = pos_t'(V_END);
   localparam pos_t V_SYNC_BEG_C = pos_t'(V_SYNC_BEG);
   localparam pos_t V_SYNC_END_C = pos_t'(V_SYNC_END);
   localparam pos_t ONE_C        = pos_t'(1);

   pos_t x_q, x_d;
   pos_t y_q, y_d;
   logic line_q, line_d;
   logic frame_q, frame_d;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;
   logic de_q, de_d;
   logic h_act, v_act;

   // Next beam position: advance one pixel per enabled cycle, wrapping line and frame.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (i_en) begin
         if (x_q == H_END_C) begin
            x_d = H_START_C;
            y_d = (y_q == V_END_C) ? V_START_C : y_q + ONE_C;
         end else begin
            x_d = x_q + ONE_C;
         end
      end
   end

   // Flags are derived from the next position so they register alongside it.
   // Levels hold while disabled; this also keeps o_de low at the reset position.
   always_comb begin
      h_act   = (x_d >= H_SYNC_BEG_C) && (x_d < H_SYNC_END_C);
      v_act   = (y_d >= V_SYNC_BEG_C) && (y_d < V_SYNC_END_C);
      line_d  = i_en && (x_d == H_START_C);
      frame_d = line_d && (y_d == V_START_C);
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      de_d    = de_q;
      if (i_en) begin
         hsync_d = h_act ? P_H_POL : ~P_H_POL;
         vsync_d = v_act ? P_V_POL : ~P_V_POL;
         de_d    = !x_d[P_COUNT_WIDTH-1] && !y_d[P_COUNT_WIDTH-1];
      end
   end

   // Position and flag registers; reset parks the beam at the last active pixel.
   always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
      if (!i_rst_n) begin
         x_q     <= H_END_C;
         y_q     <= V_END_C;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
         hsync_q <= ~P_H_POL;
         vsync_q <= ~P_V_POL;
         de_q    <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         line_q  <= line_d;
         frame_q <= frame_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
      end
   end

   assign o_x_pos = x_q;
   assign o_y_pos = y_q;
   assign o_line  = line_q;
   assign o_frame = frame_q;
   assign o_hsync = hsync_q;
   assign o_vsync = vsync_q;
   assign o_de    = de_q;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Counter steps on the same edge that raises o_frame; natural 16-bit wrap.
   always_comb begin
      frame_cnt_d = frame_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end

   // Frame counter register.
   always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
      if (!i_rst_n) begin
         frame_cnt_q <= 16'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: one DUT with default 640x480 timing, one with a tiny
// active-high raster (8x4, H 2/3/1, V 1/2/1) so whole frames fit in a short run.
module tb_video_timing_gen;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic en = 1'b0;

   always #5 clk = ~clk;

   logic signed [W-1:0] dx, dy, sx, sy;
   logic dl, df, dh, dv, dd;
   logic sl, sf, sh, sv, sd;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
   logic [15:0] dcnt, scnt;
`endif

   video_timing_gen u_dut_d (
      .i_clk_pixel (clk),
      .i_rst_n     (rst_n),
      .i_en        (en),
      .o_x_pos     (dx),
      .o_y_pos     (dy),
      .o_line      (dl),
      .o_frame     (df),
      .o_hsync     (dh),
      .o_vsync     (dv),
      .o_de        (dd)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
      ,
      .o_frame_cnt (dcnt)
`endif
   );

   video_timing_gen #(
      .P_H_RES  (8),
      .P_H_FP   (2),
      .P_H_SYNC (3),
      .P_H_BP   (1),
      .P_V_RES  (4),
      .P_V_FP   (1),
      .P_V_SYNC (2),
      .P_V_BP   (1),
      .P_H_POL  (1'b1),
      .P_V_POL  (1'b1)
   ) u_dut_s (
      .i_clk_pixel (clk),
      .i_rst_n     (rst_n),
      .i_en        (en),
      .o_x_pos     (sx),
      .o_y_pos     (sy),
      .o_line      (sl),
      .o_frame     (sf),
      .o_hsync     (sh),
      .o_vsync     (sv),
      .o_de        (sd)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
      ,
      .o_frame_cnt (scnt)
`endif
   );

   int tests = 0;
   int fails = 0;

   // Reference model: raw counters from 0 at the first blanking pixel.
   int  dhc, dvc, shc, svc, dfc, sfc;
   bit  stepped, fresh;

   // Statistics gathered during the long scan.
   int hs_y0, de_y0, vs_low;
   int s_de, s_hs, s_vs, s_frames, s_last, s_period;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      dhc = 799; dvc = 524; shc = 13; svc = 7;
      dfc = 0; sfc = 0;
      stepped = 1'b0; fresh = 1'b1;
   endtask

   task automatic adv(inout int hc, inout int vc, input int ht, input int vt);
      if (hc == ht - 1) begin
         hc = 0;
         vc = (vc == vt - 1) ? 0 : vc + 1;
      end else begin
         hc = hc + 1;
      end
   endtask

   task automatic chk_all();
      chk("d.x", dx, dhc - 160);
      chk("d.y", dy, dvc - 45);
      chk("d.line", dl, stepped && dhc == 0);
      chk("d.frame", df, stepped && dhc == 0 && dvc == 0);
      chk("d.hsync", dh, (dhc >= 16 && dhc < 112) ? 0 : 1);
      chk("d.vsync", dv, (dvc >= 10 && dvc < 12) ? 0 : 1);
      chk("d.de", dd, !fresh && dhc >= 160 && dvc >= 45);
      chk("s.x", sx, shc - 6);
      chk("s.y", sy, svc - 4);
      chk("s.line", sl, stepped && shc == 0);
      chk("s.frame", sf, stepped && shc == 0 && svc == 0);
      chk("s.hsync", sh, (shc >= 2 && shc < 5) ? 1 : 0);
      chk("s.vsync", sv, (svc >= 1 && svc < 3) ? 1 : 0);
      chk("s.de", sd, !fresh && shc >= 6 && svc >= 4);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
      chk("d.cnt", dcnt, dfc);
      chk("s.cnt", scnt, sfc);
`endif
   endtask

   // One clock with the given enable; sample 1 time unit after the edge.
   task automatic step(input bit e);
      en = e;
      @(posedge clk);
      #1;
      stepped = e;
      if (e) begin
         adv(dhc, dvc, 800, 525);
         adv(shc, svc, 14, 8);
         fresh = 1'b0;
         if (dhc == 0 && dvc == 0) dfc = (dfc + 1) % 65536;
         if (shc == 0 && svc == 0) sfc = (sfc + 1) % 65536;
      end
      chk_all();
   endtask

   task automatic accum(input int k);
      if (dy == 0 && dh == 1'b0) hs_y0++;
      if (dy == 0 && dd) de_y0++;
      if (dv == 1'b0) vs_low++;
      if (k <= 112) begin
         if (sd) s_de++;
         if (sh) s_hs++;
         if (sv) s_vs++;
      end
      if (sf) begin
         if (s_last > 0) s_period = k - s_last;
         s_last = k;
         s_frames++;
      end
   endtask

   initial begin
      int n;
      hs_y0 = 0; de_y0 = 0; vs_low = 0;
      s_de = 0; s_hs = 0; s_vs = 0; s_frames = 0; s_last = 0; s_period = 0;
      model_reset();

      // Reset state.
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_all();
      chk("rst.d.x", dx, 639);
      chk("rst.d.y", dy, 479);
      chk("rst.s.hsync", sh, 0);

      // First enabled cycle lands on the raster origin with both strobes.
      rst_n = 1'b1;
      step(1'b1);
      chk("first.d.x", dx, -160);
      chk("first.d.y", dy, -45);
      chk("first.d.frame", df, 1);
      chk("first.d.line", dl, 1);
      chk("first.d.de", dd, 0);
      chk("first.s.x", sx, -6);
      chk("first.s.y", sy, -4);
      chk("first.s.frame", sf, 1);
      accum(1);

      // Scan through line y=10 of the default raster.
      for (int k = 2; k <= 44800; k++) begin
         step(1'b1);
         accum(k);
      end
      chk("wrap.pre.x", dx, 639);
      chk("wrap.pre.y", dy, 10);
      step(1'b1);
      chk("wrap.post.x", dx, -160);
      chk("wrap.post.y", dy, 11);
      chk("wrap.post.line", dl, 1);
      chk("wrap.post.frame", df, 0);

      chk("hsync.y0.cycles", hs_y0, 96);
      chk("de.y0.cycles", de_y0, 640);
      chk("vsync.cycles", vs_low, 1600);
      chk("s.de.frame", s_de, 32);
      chk("s.hsync.frame", s_hs, 24);
      chk("s.vsync.frame", s_vs, 28);
      chk("s.frame.period", s_period, 112);
      chk("s.frame.count", s_frames, 400);

      // Stall on the last pixel of line 11.
      for (int i = 0; i < 799; i++) step(1'b1);
      chk("stall.pre.x", dx, 639);
      for (int i = 0; i < 5; i++) begin
         step(1'b0);
         chk("stall.x", dx, 639);
         chk("stall.y", dy, 11);
         chk("stall.line", dl, 0);
      end
      step(1'b1);
      chk("resume.x", dx, -160);
      chk("resume.y", dy, 12);
      chk("resume.line", dl, 1);
      step(1'b1);
      chk("resume.line2", dl, 0);

      // Mid-frame reset at (300,20).
      n = 0;
      while (!(dx == 300 && dy == 20) && n < 10000) begin
         step(1'b1);
         n++;
      end
      chk("reach.300_20", (dx == 300 && dy == 20), 1);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_all();
      chk("midrst.x", dx, 639);
      chk("midrst.y", dy, 479);
      chk("midrst.de", dd, 0);
      en = 1'b1;
      @(posedge clk); #1;
      chk_all();
      chk("midrst.hold.line", dl, 0);

      // Restart; three frame strobes on the small raster.
      rst_n = 1'b1;
      for (int i = 0; i < 225; i++) step(1'b1);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
      chk("cnt.s.three", scnt, 3);
      chk("cnt.d.one", dcnt, 1);
`endif
      chk("restart.s.frame", sf, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
